wr_full_ctrl_unit: RTL and testbench

Write-domain flow-control block for the dual-port asynchronous FIFO. It owns the write counter, gates write requests against a full condition, and publishes a Gray-coded write pointer for the read domain. It also brings the read domain's Gray-coded read counter into `clk_write` through a 2-flop synchronizer. The block sits between the producer interface and the dual-port storage array, and mirrors the read-side control in the opposite clock domain.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/ptr_sync_2ff.sv | 24 ++
 rtl/wr_full_ctrl_unit.sv | 74 +++++++
 tb/tb_wr_full_ctrl_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray conversion, depth and pointer reset value.
// Conversions work on a wide zero-extended vector; callers size-cast the result to their pointer width.
package fifo_pkg;

    localparam int PTR_MAX_W = 32;

    localparam logic [PTR_MAX_W-1:0] PTR_RST_VAL = '0;

    function automatic int depth_of(input int ptr_width);
        return 1 << ptr_width;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2 doubling steps.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin = gray;
        for (int s = 1; s < PTR_MAX_W; s = s * 2) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
// Latency is two local clock edges; both stages clear on the asynchronous reset.
module ptr_sync_2ff #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [width-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/wr_full_ctrl_unit.sv
// Write-side control of the async FIFO: write counter, Gray pointer out, synced read pointer in,
// registered full flag, occupancy estimate, almost-full and a one-cycle overflow pulse.
module wr_full_ctrl_unit
    import fifo_pkg::*;
#(
    parameter int stk_ptr_width = 3,
    parameter int af_margin     = 1
) (
    input  logic                     clk_write,
    input  logic                     rst,
    input  logic                     write_to_stk,
    input  logic [stk_ptr_width:0]   rd_cntr_gray,
    output logic [stk_ptr_width:0]   wr_cntr,
    output logic [stk_ptr_width:0]   wr_cntr_gray,
    output logic [stk_ptr_width-1:0] write_ptr,
    output logic                     write_en,
    output logic                     stk_full,
    output logic                     stk_almost_full,
    output logic [stk_ptr_width:0]   wr_level,
    output logic                     wr_overflow
);

    localparam int W     = stk_ptr_width;
    localparam int PW    = stk_ptr_width + 1;
    localparam int DEPTH = depth_of(stk_ptr_width);

    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - af_margin);

    logic [PW-1:0] wr_cntr_nxt;
    logic [PW-1:0] wr_gray_nxt;
    logic [PW-1:0] rd_sync2;
    logic [PW-1:0] rd_sync_bin;
    logic [PW-1:0] full_match;
    logic          full_nxt;

    ptr_sync_2ff #(
        .width (PW)
    ) u_rd_sync (
        .clk   (clk_write),
        .rst   (rst),
        .din   (rd_cntr_gray),
        .dout  (rd_sync2)
    );

    assign write_en    = write_to_stk & ~stk_full;
    assign write_ptr   = wr_cntr[W-1:0];
    assign wr_cntr_nxt = wr_cntr + {{(PW-1){1'b0}}, write_en};
    assign wr_gray_nxt = PW'(bin2gray(PTR_MAX_W'(wr_cntr_nxt)));

    // Full when the next write pointer sits exactly one lap ahead of the synced read pointer;
    // in Gray code that is the read pointer with its top two bits inverted.
    assign full_match  = {~rd_sync2[W:W-1], rd_sync2[W-2:0]};
    assign full_nxt    = (wr_gray_nxt == full_match);

    // The read pointer seen here is stale, so this never undercounts the true occupancy.
    assign rd_sync_bin     = PW'(gray2bin(PTR_MAX_W'(rd_sync2)));
    assign wr_level        = wr_cntr - rd_sync_bin;
    assign stk_almost_full = (wr_level >= AF_LEVEL);

    always_ff @(posedge clk_write or posedge rst) begin
        if (rst) begin
            wr_cntr      <= PW'(PTR_RST_VAL);
            wr_cntr_gray <= PW'(PTR_RST_VAL);
            stk_full     <= 1'b0;
            wr_overflow  <= 1'b0;
        end else begin
            wr_cntr      <= wr_cntr_nxt;
            wr_cntr_gray <= wr_gray_nxt;
            stk_full     <= full_nxt;
            wr_overflow  <= write_to_stk & stk_full;
        end
    end

endmodule

// File: tb/tb_wr_full_ctrl_unit.sv
// Scoreboarded bench for wr_full_ctrl_unit at stk_ptr_width=3, af_margin=1.
module tb_wr_full_ctrl_unit;

    localparam int W  = 3;
    localparam int PW = W + 1;

    logic          clk_write    = 1'b0;
    logic          rst          = 1'b1;
    logic          write_to_stk = 1'b0;
    logic [PW-1:0] rd_cntr_gray = '0;
    logic [PW-1:0] wr_cntr;
    logic [PW-1:0] wr_cntr_gray;
    logic [W-1:0]  write_ptr;
    logic          write_en;
    logic          stk_full;
    logic          stk_almost_full;
    logic [PW-1:0] wr_level;
    logic          wr_overflow;

    wr_full_ctrl_unit #(
        .stk_ptr_width (W),
        .af_margin     (1)
    ) dut (
        .clk_write       (clk_write),
        .rst             (rst),
        .write_to_stk    (write_to_stk),
        .rd_cntr_gray    (rd_cntr_gray),
        .wr_cntr         (wr_cntr),
        .wr_cntr_gray    (wr_cntr_gray),
        .write_ptr       (write_ptr),
        .write_en        (write_en),
        .stk_full        (stk_full),
        .stk_almost_full (stk_almost_full),
        .wr_level        (wr_level),
        .wr_overflow     (wr_overflow)
    );

    always #5 clk_write = ~clk_write;

    typedef struct {
        logic [PW-1:0] cntr;
        logic [PW-1:0] gray;
        logic          full;
        logic [PW-1:0] level;
        logic          af;
        logic          ovf;
        logic          acc;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: committed write count, the two synchronizer stages, full and read count.
    logic [PW-1:0] m_cntr, m_s1, m_s2, rd_b;
    logic          m_full;

    function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic m_reset();
        m_cntr = '0;
        m_s1   = '0;
        m_s2   = '0;
        m_full = 1'b0;
        rd_b   = '0;
        sb_q.delete();
    endtask

    // One write-clock cycle: drive at the falling edge, check the combinational strobe,
    // push the predicted post-edge state, then pop and compare just after the rising edge.
    task automatic step(input logic req, input logic [PW-1:0] rdg, output logic acc);
        exp_t          e;
        exp_t          got;
        logic [PW-1:0] nxt;
        logic [PW-1:0] prev_gray;
        @(negedge clk_write);
        write_to_stk = req;
        rd_cntr_gray = rdg;
        #1;
        e.acc = req & ~m_full;
        check_val("write_en", write_en, e.acc);
        check_val("write_ptr", write_ptr, m_cntr[W-1:0]);
        nxt     = m_cntr + {3'b000, e.acc};
        e.cntr  = nxt;
        e.gray  = b2g(nxt);
        e.full  = ((nxt - g2b(m_s2)) == 4'd8);
        e.ovf   = req & m_full;
        e.level = nxt - g2b(m_s1);
        e.af    = (e.level >= 4'd7);
        sb_q.push_back(e);
        m_cntr = nxt;
        m_full = e.full;
        m_s2   = m_s1;
        m_s1   = rdg;
        prev_gray = wr_cntr_gray;
        @(posedge clk_write);
        #1;
        got = sb_q.pop_front();
        check_val("wr_cntr", wr_cntr, got.cntr);
        check_val("wr_cntr_gray", wr_cntr_gray, got.gray);
        check_val("gray_bits_changed", $countones(wr_cntr_gray ^ prev_gray), got.acc);
        check_val("stk_full", stk_full, got.full);
        check_val("wr_level", wr_level, got.level);
        check_val("stk_almost_full", stk_almost_full, got.af);
        check_val("wr_overflow", wr_overflow, got.ovf);
        acc = got.acc;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_wr_cntr"}, wr_cntr, 0);
        check_val({tag, "_gray"}, wr_cntr_gray, 0);
        check_val({tag, "_ptr"}, write_ptr, 0);
        check_val({tag, "_full"}, stk_full, 0);
        check_val({tag, "_af"}, stk_almost_full, 0);
        check_val({tag, "_level"}, wr_level, 0);
        check_val({tag, "_ovf"}, wr_overflow, 0);
        check_val({tag, "_we"}, write_en, 0);
    endtask

    initial begin
        logic       acc;
        logic [3:0] sim_acc;
        int         accepted;
        logic [PW-1:0] prev_cntr;
        logic       saw_wrap;

        m_reset();
        #12;
        check_all_zero("por");
        @(negedge clk_write);
        rst = 1'b0;

        // Reset in the middle of traffic with wr_cntr = 5.
        for (int i = 0; i < 5; i++) step(1'b1, '0, acc);
        check_val("pre_rst_cntr", wr_cntr, 5);
        write_to_stk = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk_write);
        rst = 1'b0;
        m_reset();

        // Fill from empty.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, '0, acc);
            if (i == 5) check_val("af_after_6", stk_almost_full, 0);
            if (i == 6) check_val("af_after_7", stk_almost_full, 1);
        end
        check_val("fill_cntr", wr_cntr, 8);
        check_val("fill_full", stk_full, 1);
        check_val("fill_level", wr_level, 8);
        check_val("fill_gray", wr_cntr_gray, 4'b1100);

        // Overflow: a 9th request is blocked and pulses wr_overflow for one cycle.
        step(1'b1, '0, acc);
        check_val("ovf_acc", acc, 0);
        check_val("ovf_pulse", wr_overflow, 1);
        check_val("ovf_cntr", wr_cntr, 8);
        step(1'b0, '0, acc);
        check_val("ovf_pulse_end", wr_overflow, 0);

        // Release: one read.
        rd_b = 4'd1;
        step(1'b0, b2g(rd_b), acc);
        check_val("rel_level_e1", wr_level, 8);
        step(1'b0, b2g(rd_b), acc);
        check_val("rel_level_e2", wr_level, 7);
        check_val("rel_full_e2", stk_full, 1);
        step(1'b0, b2g(rd_b), acc);
        check_val("rel_full_e3", stk_full, 0);
        check_val("rel_ptr", write_ptr, 0);
        step(1'b1, b2g(rd_b), acc);
        check_val("rel_acc", acc, 1);
        check_val("rel_refull", stk_full, 1);

        // Simultaneous: requests every cycle while a read propagates through the synchronizer.
        rd_b = 4'd2;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, b2g(rd_b), acc);
            sim_acc[i] = acc;
        end
        check_val("sim_accept_pattern", sim_acc, 4'b1000);

        // Wrap-around with the read side draining.
        accepted = 0;
        saw_wrap = 1'b0;
        for (int cyc = 0; cyc < 300 && accepted < 40; cyc++) begin
            if ((m_cntr - rd_b) != 0 && $urandom_range(0, 3) != 0) rd_b = rd_b + 1'b1;
            prev_cntr = wr_cntr;
            step(1'b1, b2g(rd_b), acc);
            if (acc) accepted++;
            if (prev_cntr == 4'd15 && wr_cntr == 4'd0) saw_wrap = 1'b1;
        end
        check_val("wrap_writes", accepted, 40);
        check_val("wrap_seen", saw_wrap, 1);

        check_val("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
